// File: rtl/wam_pkg.sv
// wam_pkg: shared state/mode encodings and lives clamp for the whack-a-mole controller
package wam_pkg;

    typedef enum logic [2:0] {
        ST_SETUP     = 3'd0,
        ST_WAIT      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_RESTART   = 3'd4
    } state_e;

    // Bit 0 of the mode marks a timed game, bit 1 a lives game.
    localparam logic [1:0] MODE_POINTS      = 2'b00;
    localparam logic [1:0] MODE_TIMED       = 2'b01;
    localparam logic [1:0] MODE_LIVES       = 2'b10;
    localparam logic [1:0] MODE_TIMED_LIVES = 2'b11;

    function automatic logic [3:0] clamp_lives(input logic [3:0] cfg, input logic [3:0] max_lives);
        return (cfg == 4'd0) ? 4'd1 : (cfg > max_lives) ? max_lives : cfg;
    endfunction

endpackage

// File: rtl/wam_epoch_scorer.sv
// wam_epoch_scorer: per-light-epoch hit/miss scoring (score, lights_done, misses)
module wam_epoch_scorer #(
    parameter int IDX_W = 4,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             light_change_i,
    input  logic [IDX_W-1:0] light_pos_i,
    input  logic             key_down_i,
    input  logic [IDX_W-1:0] key_idx_i,
    output logic             miss_o,
    output logic [CW-1:0]    score_o,
    output logic [CW-1:0]    lights_done_o,
    output logic [CW-1:0]    misses_o
);

    logic          open_q, open_d, hit_q, hit_d, hit_now, close;
    logic [CW-1:0] score_q, score_d, done_q, done_d, miss_q, miss_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
        return (inc && v != '1) ? v + CW'(1) : v;
    endfunction

    assign hit_now       = en_i && key_down_i && open_q && !hit_q && key_idx_i == light_pos_i;
    assign close         = en_i && light_change_i && open_q;
    assign miss_o        = close && !(hit_q || hit_now);
    assign score_o       = score_q;
    assign lights_done_o = done_q;
    assign misses_o      = miss_q;

    // A light change always opens a fresh epoch; a press in the same cycle still counts for the closing one
    always_comb begin
        open_d  = clr_i ? 1'b0 : (open_q || (en_i && light_change_i));
        hit_d   = (clr_i || (en_i && light_change_i)) ? 1'b0 : (hit_q || hit_now);
        score_d = clr_i ? '0 : sat_inc(score_q, hit_now);
        done_d  = clr_i ? '0 : sat_inc(done_q, close);
        miss_d  = clr_i ? '0 : sat_inc(miss_q, miss_o);
    end

    // Epoch and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            open_q  <= 1'b0;
            hit_q   <= 1'b0;
            score_q <= '0;
            done_q  <= '0;
            miss_q  <= '0;
        end else begin
            open_q  <= open_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

endmodule

// File: rtl/wam_game_ctrl.sv
// wam_game_ctrl: whack-a-mole session FSM, ready countdown, game timer and lives (optional HIGH_SCORE_EN adds best_score)
module wam_game_ctrl import wam_pkg::*; #(
    parameter int NUM_LIGHTS  = 9,
    parameter int NORMAL_HITS = 25,
    parameter int EXT_HITS    = 50,
    parameter int GAME_SECS   = 60,
    parameter int READY_SECS  = 5,
    parameter int MAX_LIVES   = 9,
    parameter int IDX_W       = $clog2(NUM_LIGHTS),
    parameter int CW          = $clog2(EXT_HITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             play,
    input  logic [1:0]       game_mode,
    input  logic             extended,
    input  logic [3:0]       lives_cfg,
    input  logic             light_change,
    input  logic [IDX_W-1:0] light_pos,
    input  logic             key_down,
    input  logic [IDX_W-1:0] key_idx,
    output logic [2:0]       state,
    output logic             flick_en,
    output logic             clear_n,
    output logic [2:0]       ready_cnt,
    output logic [CW-1:0]    score,
    output logic [CW-1:0]    lights_done,
    output logic [CW-1:0]    misses,
    output logic [3:0]       lives_left,
    output logic [5:0]       time_left,
`ifdef HIGH_SCORE_EN
    output logic [CW-1:0]    best_score,
`endif
    output logic             game_over
);

    state_e        state_q, state_d;
    logic [2:0]    ready_q, ready_d;
    logic [5:0]    time_q, time_d;
    logic [3:0]    lives_q, lives_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] target_q, target_d;
    logic          go, miss, end_cond;

    // A play pulse restarts from anywhere except the one-cycle RESTART itself
    assign go       = play && state_q != ST_RESTART;
    assign end_cond = (mode_q == MODE_POINTS && lights_done == target_q)
                   || (mode_q[0] && time_q == 6'd0)
                   || (mode_q[1] && lives_q == 4'd0);

    wam_epoch_scorer #(.IDX_W(IDX_W), .CW(CW)) u_scorer (
        .clk           (clk),
        .reset         (reset),
        .clr_i         (go),
        .en_i          (state_q == ST_PLAY && !go),
        .light_change_i(light_change),
        .light_pos_i   (light_pos),
        .key_down_i    (key_down),
        .key_idx_i     (key_idx),
        .miss_o        (miss),
        .score_o       (score),
        .lights_done_o (lights_done),
        .misses_o      (misses)
    );

    // Next state, countdown, timer and lives; game settings are latched only when a restart begins
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        time_d   = time_q;
        lives_d  = lives_q;
        mode_d   = mode_q;
        target_d = target_q;
        if (go) begin
            state_d  = ST_RESTART;
            ready_d  = 3'(READY_SECS);
            time_d   = 6'(GAME_SECS);
            lives_d  = clamp_lives(lives_cfg, 4'(MAX_LIVES));
            mode_d   = game_mode;
            target_d = extended ? CW'(EXT_HITS) : CW'(NORMAL_HITS);
        end else begin
            case (state_q)
                ST_RESTART: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (tick_1hz) begin
                        ready_d = (ready_q != 3'd0) ? ready_q - 3'd1 : ready_q;
                        state_d = (ready_q <= 3'd1) ? ST_PLAY : ST_WAIT;
                    end
                end
                ST_PLAY: begin
                    state_d = end_cond ? ST_GAME_OVER : ST_PLAY;
                    time_d  = (tick_1hz && mode_q[0] && time_q != 6'd0) ? time_q - 6'd1 : time_q;
                    lives_d = (miss && mode_q[1] && lives_q != 4'd0) ? lives_q - 4'd1 : lives_q;
                end
                default: ;
            endcase
        end
    end

    // Session registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_SETUP;
            ready_q  <= 3'(READY_SECS);
            time_q   <= 6'(GAME_SECS);
            lives_q  <= 4'd0;
            mode_q   <= MODE_POINTS;
            target_q <= CW'(NORMAL_HITS);
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            time_q   <= time_d;
            lives_q  <= lives_d;
            mode_q   <= mode_d;
            target_q <= target_d;
        end
    end

    assign state      = state_q;
    assign flick_en   = state_q == ST_PLAY;
    assign clear_n    = state_q != ST_RESTART;
    assign game_over  = state_q == ST_GAME_OVER;
    assign ready_cnt  = ready_q;
    assign time_left  = time_q;
    assign lives_left = lives_q;

`ifdef HIGH_SCORE_EN
    logic [CW-1:0] best_q;

    // Capture a better score as the game ends; kept across restarts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) best_q <= '0;
        else if (state_d == ST_GAME_OVER && state_q != ST_GAME_OVER && score > best_q) best_q <= score;
    end

    assign best_score = best_q;
`endif

endmodule
